// File: rtl/h2bp.sv
// Shared types and constants for the issue stage.
// Latency: none; this file holds declarations only.
// Backpressure: none; this file holds declarations only.
package h2bp;

   localparam int NUM_REGS = 32;

   typedef enum logic {
      MEM_IDLE = 1'b0,
      MEM_BUSY = 1'b1
   } mem_state_t;

   typedef enum logic [1:0] {
      UNIT_NONE = 2'd0,
      UNIT_ALU  = 2'd1,
      UNIT_FPU  = 2'd2,
      UNIT_MEM  = 2'd3
   } unit_sel_t;

   // Memory ops take priority over FPU, and FPU takes priority over ALU.
   function automatic unit_sel_t sel_unit(input logic is_load, input logic is_store,
                                          input logic use_fpu, input logic use_alu);
      unit_sel_t u;
      if (is_load || is_store) u = UNIT_MEM;
      else if (use_fpu)        u = UNIT_FPU;
      else if (use_alu)        u = UNIT_ALU;
      else                     u = UNIT_NONE;
      return u;
   endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Register scoreboard: one pending-write bit per register, with one set port and three clear ports.
// Latency: set/clear take effect at the next edge; lookups read the registered bits combinationally.
// Backpressure: none; callers decide when to stall on a busy bit.
module issue_scoreboard
   import h2bp::*;
#(
   parameter int NREGS = NUM_REGS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set_en,
   input  logic [4:0]       set_addr,
   input  logic             alu_clr_en,
   input  logic [4:0]       alu_clr_addr,
   input  logic             fpu_clr_en,
   input  logic [4:0]       fpu_clr_addr,
   input  logic             mem_clr_en,
   input  logic [4:0]       mem_clr_addr,
   input  logic [4:0]       look_a_addr,
   input  logic [4:0]       look_b_addr,
   input  logic [4:0]       look_c_addr,
   output logic             look_a_busy,
   output logic             look_b_busy,
   output logic             look_c_busy,
   output logic [NREGS-1:0] busy
);

   logic [NREGS-1:0] busy_q;

   // Addresses beyond the scoreboard size are never busy.
   function automatic logic lookup(input logic [NREGS-1:0] bits, input logic [4:0] a);
      logic r;
      r = 1'b0;
      for (int i = 0; i < NREGS; i++) begin
         if (a == 5'(i)) r = bits[i];
      end
      return r;
   endfunction

   // Per-bit update: a set in the same cycle as any clear of that register wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (set_en && set_addr == 5'(i))
               busy_q[i] <= 1'b1;
            else if ((alu_clr_en && alu_clr_addr == 5'(i)) ||
                     (fpu_clr_en && fpu_clr_addr == 5'(i)) ||
                     (mem_clr_en && mem_clr_addr == 5'(i)))
               busy_q[i] <= 1'b0;
         end
      end
   end

   assign look_a_busy = lookup(busy_q, look_a_addr);
   assign look_b_busy = lookup(busy_q, look_b_addr);
   assign look_c_busy = lookup(busy_q, look_c_addr);
   assign busy        = busy_q;

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue control: RAW/WAW hazard checks against a scoreboard, dispatch to ALU, FPU or memory.
// Latency: issue is combinational in the accept cycle; scoreboard bits set at the following edge.
// Backpressure: dec_ready drops on any hazard, FPU not ready, or memory busy; stalled cycles are counted.
module issue_ctrl
   import h2bp::*;
#(
   parameter int NUM_REGS = h2bp::NUM_REGS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                dec_valid,
   output logic                dec_ready,
   input  logic [4:0]          dec_rd,
   input  logic [4:0]          dec_rs1,
   input  logic [4:0]          dec_rs2,
   input  logic                dec_opa_en,
   input  logic                dec_opb_en,
   input  logic                dec_res_en,
   input  logic                dec_rd_is_opa,
   input  logic                dec_use_alu,
   input  logic                dec_use_fpu,
   input  logic                dec_is_load,
   input  logic                dec_is_store,
   output logic                alu_issue,
   output logic                fpu_issue,
   input  logic                fpu_ready,
   input  logic                fpu_done,
   input  logic [4:0]          fpu_done_rd,
   output logic                mem_issue,
   input  logic                mem_ack,
   output logic [NUM_REGS-1:0] busy,
   output logic [15:0]         stall_cnt
);

   unit_sel_t  unit;
   mem_state_t state_q, state_d;
   logic       busy_rs1, busy_rs2, busy_rd;
   logic       writes_rd, raw, waw, avail, issue;
   logic       alu_pend_vld, mem_rd_vld;
   logic [4:0] alu_pend_rd, mem_rd;

   assign unit      = sel_unit(dec_is_load, dec_is_store, dec_use_fpu, dec_use_alu);
   assign writes_rd = dec_res_en && !dec_is_store;

   // Hazard detection and unit availability from registered busy bits (no bypass).
   always_comb begin
      raw   = (dec_opa_en && busy_rs1) || (dec_opb_en && busy_rs2) || (dec_rd_is_opa && busy_rd);
      waw   = writes_rd && busy_rd;
      avail = 1'b1;
      case (unit)
         UNIT_FPU: avail = fpu_ready;
         UNIT_MEM: avail = (state_q == MEM_IDLE);
         default:  avail = 1'b1;
      endcase
   end

   assign dec_ready = !rst && !raw && !waw && avail;
   assign issue     = dec_valid && dec_ready;
   assign alu_issue = issue && (unit == UNIT_ALU);
   assign fpu_issue = issue && (unit == UNIT_FPU);
   assign mem_issue = issue && (unit == UNIT_MEM);

   issue_scoreboard #(.NREGS(NUM_REGS)) u_sb (
      .clk          (clk),
      .rst          (rst),
      .set_en       (issue && writes_rd && (unit != UNIT_NONE)),
      .set_addr     (dec_rd),
      .alu_clr_en   (alu_pend_vld),
      .alu_clr_addr (alu_pend_rd),
      .fpu_clr_en   (fpu_done),
      .fpu_clr_addr (fpu_done_rd),
      .mem_clr_en   ((state_q == MEM_BUSY) && mem_ack && mem_rd_vld),
      .mem_clr_addr (mem_rd),
      .look_a_addr  (dec_rs1),
      .look_b_addr  (dec_rs2),
      .look_c_addr  (dec_rd),
      .look_a_busy  (busy_rs1),
      .look_b_busy  (busy_rs2),
      .look_c_busy  (busy_rd),
      .busy         (busy)
   );

   // Track the ALU result (cleared one edge after set) and the outstanding load destination.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_pend_vld <= 1'b0;
         alu_pend_rd  <= '0;
         mem_rd_vld   <= 1'b0;
         mem_rd       <= '0;
      end else begin
         alu_pend_vld <= alu_issue && writes_rd;
         alu_pend_rd  <= dec_rd;
         if (mem_issue) begin
            mem_rd_vld <= writes_rd;
            mem_rd     <= dec_rd;
         end
      end
   end

   // Memory FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= MEM_IDLE;
      else     state_q <= state_d;
   end

   // Memory FSM next state: one access in flight at a time; ack outside MEM_BUSY is ignored.
   always_comb begin
      state_d = state_q;
      case (state_q)
         MEM_IDLE: if (mem_issue) state_d = MEM_BUSY;
         MEM_BUSY: if (mem_ack)   state_d = MEM_IDLE;
         default:                 state_d = MEM_IDLE;
      endcase
   end

   // Saturating count of cycles where the decoder was held off.
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (dec_valid && !dec_ready && stall_cnt != 16'hFFFF)
         stall_cnt <= stall_cnt + 16'd1;
   end

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl with a scoreboard queue of expected issue pulses.
// Latency: expected pulses are tagged with the cycle they must appear in.
// Backpressure: stalls are checked through dec_ready, busy and stall_cnt.
module tb_issue_ctrl;
   import h2bp::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        dec_valid, dec_ready;
   logic [4:0]  dec_rd, dec_rs1, dec_rs2;
   logic        dec_opa_en, dec_opb_en, dec_res_en, dec_rd_is_opa;
   logic        dec_use_alu, dec_use_fpu, dec_is_load, dec_is_store;
   logic        alu_issue, fpu_issue, mem_issue;
   logic        fpu_ready, fpu_done, mem_ack;
   logic [4:0]  fpu_done_rd;
   logic [31:0] busy;
   logic [15:0] stall_cnt;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      int unit;
      int cyc;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;
   int   mon_unit, mon_n;

   issue_ctrl #(.NUM_REGS(32)) dut (
      .clk(clk), .rst(rst),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .dec_opa_en(dec_opa_en), .dec_opb_en(dec_opb_en),
      .dec_res_en(dec_res_en), .dec_rd_is_opa(dec_rd_is_opa),
      .dec_use_alu(dec_use_alu), .dec_use_fpu(dec_use_fpu),
      .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
      .alu_issue(alu_issue), .fpu_issue(fpu_issue),
      .fpu_ready(fpu_ready), .fpu_done(fpu_done), .fpu_done_rd(fpu_done_rd),
      .mem_issue(mem_issue), .mem_ack(mem_ack),
      .busy(busy), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic expect_issue(input int unit);
      exp_t e;
      e.unit = unit;
      e.cyc  = cyc;
      exp_q.push_back(e);
   endtask

   // args: valid, alu, fpu, load, store, rd, rs1, rs2, opa_en, opb_en, res_en, rd_is_opa
   task automatic inst(input bit v, input bit alu, input bit fpu, input bit ld, input bit st,
                       input int rd, input int rs1, input int rs2,
                       input bit opa, input bit opb, input bit res, input bit rdopa);
      dec_valid = v;    dec_use_alu = alu; dec_use_fpu = fpu;
      dec_is_load = ld; dec_is_store = st;
      dec_rd = 5'(rd);  dec_rs1 = 5'(rs1); dec_rs2 = 5'(rs2);
      dec_opa_en = opa; dec_opb_en = opb; dec_res_en = res; dec_rd_is_opa = rdopa;
   endtask

   task automatic idle();
      inst(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: every issue pulse must match the head of the expected queue in unit and cycle.
   always @(negedge clk) begin
      if (alu_issue || fpu_issue || mem_issue) begin
         checks++;
         mon_n    = int'(alu_issue) + int'(fpu_issue) + int'(mem_issue);
         mon_unit = alu_issue ? 1 : (fpu_issue ? 2 : 3);
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL issue_unexpected: got unit %0d at cycle %0d expected no issue", mon_unit, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.unit != mon_unit || mon_e.cyc != cyc || mon_n != 1) begin
               errors++;
               $display("FAIL issue_pulse: got unit %0d (pulses %0d) at cycle %0d expected unit %0d at cycle %0d",
                        mon_unit, mon_n, cyc, mon_e.unit, mon_e.cyc);
            end
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; fpu_ready = 1'b1; fpu_done = 1'b0; fpu_done_rd = '0; mem_ack = 1'b0;
      idle();
      // Reset cycle with a valid request present: nothing may issue.
      step(); inst(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
      smp(); chk("rst_ready", 32'(dec_ready), 0);
      step(); rst = 1'b0; idle();
      smp(); chk("rst_busy", busy, 0); chk("rst_stall", 32'(stall_cnt), 0);

      // ALU RAW through rs1.
      step(); inst(1, 1, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0); expect_issue(1);
      smp(); chk("alu_first_ready", 32'(dec_ready), 1);
      step(); inst(1, 1, 0, 0, 0, 4, 3, 0, 1, 0, 1, 0);
      smp(); chk("alu_raw_busy", busy, 32'h0000_0008); chk("alu_raw_stall", 32'(dec_ready), 0);
      step(); expect_issue(1);
      smp(); chk("alu_raw_issue", 32'(dec_ready), 1); chk("alu_raw_clr", busy, 0);
      chk("alu_raw_cnt", 32'(stall_cnt), 1);
      step(); idle();
      smp(); chk("alu_rd4_busy", busy, 32'h0000_0010);
      // RAW through rs2.
      step(); inst(1, 1, 0, 0, 0, 11, 0, 0, 0, 0, 1, 0); expect_issue(1);
      step(); inst(1, 1, 0, 0, 0, 12, 0, 11, 0, 1, 1, 0);
      smp(); chk("opb_raw_stall", 32'(dec_ready), 0);
      step(); expect_issue(1);
      smp(); chk("opb_raw_issue", 32'(dec_ready), 1);
      // RAW through rd used as a source.
      step(); inst(1, 1, 0, 0, 0, 13, 0, 0, 0, 0, 1, 0); expect_issue(1);
      step(); inst(1, 1, 0, 0, 0, 13, 0, 0, 0, 0, 0, 1);
      smp(); chk("rdopa_raw_stall", 32'(dec_ready), 0);
      step(); expect_issue(1);
      smp(); chk("rdopa_raw_issue", 32'(dec_ready), 1);
      // No-op: accepted, no pulse.
      step(); inst(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      smp(); chk("noop_ready", 32'(dec_ready), 1);
      step(); idle();
      smp(); chk("noop_busy", busy, 0); chk("noop_cnt", 32'(stall_cnt), 3);

      // FPU WAW on r20, released by fpu_done.
      step(); inst(1, 0, 1, 0, 0, 20, 0, 0, 0, 0, 1, 0); expect_issue(2);
      smp(); chk("fpu_first_ready", 32'(dec_ready), 1);
      step(); inst(1, 0, 1, 0, 0, 20, 0, 0, 0, 0, 1, 0);
      smp(); chk("fpu_waw_busy", busy, 32'h0010_0000); chk("fpu_waw_stall", 32'(dec_ready), 0);
      step(); fpu_done = 1'b1; fpu_done_rd = 5'd20;
      smp(); chk("fpu_done_nobypass", 32'(dec_ready), 0);
      step(); fpu_done = 1'b0; expect_issue(2);
      smp(); chk("fpu_waw_issue", 32'(dec_ready), 1); chk("fpu_waw_clr", busy, 0);
      chk("fpu_waw_cnt", 32'(stall_cnt), 5);
      step(); idle();
      smp(); chk("fpu_second_busy", busy, 32'h0010_0000);
      step(); fpu_done = 1'b1; fpu_done_rd = 5'd20;
      // FPU not ready holds the instruction.
      step(); fpu_done = 1'b0; fpu_ready = 1'b0; inst(1, 0, 1, 0, 0, 21, 0, 0, 0, 0, 1, 0);
      smp(); chk("fpu_nr_busy", busy, 0); chk("fpu_nr_stall", 32'(dec_ready), 0);
      step(); fpu_ready = 1'b1; expect_issue(2);
      smp(); chk("fpu_nr_issue", 32'(dec_ready), 1); chk("fpu_nr_cnt", 32'(stall_cnt), 6);
      step(); idle();
      smp(); chk("fpu_r21_busy", busy, 32'h0020_0000);
      step(); fpu_done = 1'b1; fpu_done_rd = 5'd21;
      step(); fpu_done = 1'b0;
      smp(); chk("fpu_r21_clr", busy, 0);

      // Memory serialisation; load also selects ALU and FPU to exercise priority.
      step(); inst(1, 1, 1, 1, 0, 5, 0, 0, 0, 0, 1, 0); expect_issue(3);
      smp(); chk("mem_load_ready", 32'(dec_ready), 1);
      step(); inst(1, 0, 0, 0, 1, 6, 0, 0, 0, 0, 1, 0);
      smp(); chk("mem_load_busy", busy, 32'h0000_0020); chk("mem_store_stall", 32'(dec_ready), 0);
      step(); mem_ack = 1'b1;
      smp(); chk("mem_ack_nobypass", 32'(dec_ready), 0);
      step(); mem_ack = 1'b0; expect_issue(3);
      smp(); chk("mem_ack_clr", busy, 0); chk("mem_store_issue", 32'(dec_ready), 1);
      step(); idle();
      smp(); chk("mem_store_nobusy", busy, 0); chk("mem_cnt", 32'(stall_cnt), 8);
      step(); mem_ack = 1'b1;
      step(); mem_ack = 1'b0;

      // Set and clear on r7 in the same cycle.
      step(); inst(1, 1, 0, 0, 0, 7, 0, 0, 0, 0, 1, 0); fpu_done = 1'b1; fpu_done_rd = 5'd7;
      expect_issue(1);
      step(); idle(); fpu_done = 1'b0;
      smp(); chk("setclr_set_wins", busy, 32'h0000_0080);
      step();
      smp(); chk("setclr_alu_clr", busy, 0);

      // Reset with a load and an FPU op outstanding.
      step(); inst(1, 0, 0, 1, 0, 5, 0, 0, 0, 0, 1, 0); expect_issue(3);
      step(); inst(1, 0, 1, 0, 0, 20, 0, 0, 0, 0, 1, 0); expect_issue(2);
      smp(); chk("pre_rst_load_busy", busy, 32'h0000_0020);
      step(); idle();
      smp(); chk("pre_rst_busy", busy, 32'h0010_0020);
      step(); rst = 1'b1; inst(1, 1, 0, 0, 0, 2, 0, 0, 0, 0, 1, 0);
      smp(); chk("mid_rst_ready", 32'(dec_ready), 0);
      step(); rst = 1'b0; idle(); mem_ack = 1'b1; fpu_done = 1'b1; fpu_done_rd = 5'd20;
      smp(); chk("post_rst_busy", busy, 0); chk("post_rst_cnt", 32'(stall_cnt), 0);
      step(); mem_ack = 1'b0; fpu_done = 1'b0; inst(1, 0, 0, 1, 0, 8, 0, 0, 0, 0, 1, 0);
      expect_issue(3);
      smp(); chk("post_rst_idle", 32'(dec_ready), 1); chk("stray_ack_busy", busy, 0);
      step(); idle();
      smp(); chk("post_rst_load_busy", busy, 32'h0000_0100);
      step(); mem_ack = 1'b1;
      step(); mem_ack = 1'b0;
      smp(); chk("post_rst_load_clr", busy, 0);

      // Saturation: hold a WAW hazard for 70000 cycles.
      step(); inst(1, 0, 1, 0, 0, 25, 0, 0, 0, 0, 1, 0); expect_issue(2);
      step(); inst(1, 0, 1, 0, 0, 25, 0, 0, 0, 0, 1, 0);
      for (int i = 1; i <= 70000; i++) begin
         step();
         if (i == 65534) begin
            smp(); chk("sat_below", 32'(stall_cnt), 32'h0000_FFFE);
         end
      end
      smp(); chk("sat_cnt", 32'(stall_cnt), 32'h0000_FFFF); chk("sat_stall", 32'(dec_ready), 0);
      step(); fpu_done = 1'b1; fpu_done_rd = 5'd25;
      step(); fpu_done = 1'b0; expect_issue(2);
      smp(); chk("sat_release", 32'(dec_ready), 1);
      step(); idle();
      step(); fpu_done = 1'b1; fpu_done_rd = 5'd25;
      step(); fpu_done = 1'b0;
      smp(); chk("final_busy", busy, 0);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_issues: got %0d left expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
